fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Program-counter and fetch controller that drives the instruction memory read port and supplies instructions to decode.
- The instruction memory is a combinational ROM: its data is valid in the same cycle as its address.
- Contains a 2-entry instruction queue with a valid/ready handshake toward decode, branch/jump redirect with flush, and start/halt control.

Parameters:
ADDR_W, 32, width of PC and memory address
DATA_W, 32, instruction width
RESET_PC, 32'h00000000, PC value loaded on reset
PC_STEP, 4, PC increment per fetched instruction

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse; leaves IDLE/HALT and begins fetching
halt_req  input  1  stop fetching; queue drains normally
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  ADDR_W  target PC, low 2 bits ignored
imem_addr  output  ADDR_W  instruction memory address (= PC register)
imem_en  output  1  high in cycles where the fetched word is captured
imem_data  input  DATA_W  instruction memory read data, combinational from imem_addr
instr_valid  output  1  queue head valid toward decode
instr_ready  input  1  decode accepts the head
instr_out  output  DATA_W  queue head instruction
instr_pc  output  ADDR_W  PC of the queue head
busy  output  1  state==FETCH or queue non-empty

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc=RESET_PC, queue count=0, state=IDLE.
  - imem_en=0, instr_valid=0, instr_out=0, instr_pc=0, busy=0.
  - Reset mid-operation discards all queue contents immediately.
- States are IDLE, FETCH and HALT.
  - IDLE->FETCH on start.
  - FETCH->HALT on halt_req.
  - HALT->FETCH on start.
  - IDLE is reached only from reset.
- imem_addr = pc at all times (registered output).
- Push condition: state==FETCH, count<2 (registered count), no redirect_valid, no halt_req.
  - When push is true: imem_en=1, {pc, imem_data} is written at the queue tail, and pc<=pc+PC_STEP.
  - PC arithmetic is modulo 2^ADDR_W: 0xFFFFFFFC+4 -> 0x00000000.
- Pop: instr_valid && instr_ready removes the head.
  - instr_valid = (count!=0) && !redirect_valid.
- Simultaneous push and pop: count is unchanged and the entries shift. A sustained instr_ready=1 therefore gives 1 instruction/cycle after a 1-cycle startup latency (the first word enters the queue at the end of the first FETCH cycle).
- Full queue (count==2): no push that cycle, even if a pop occurs; pc holds.
- Redirect (redirect_valid=1, any state):
  - Next cycle: count=0 and pc={redirect_pc[ADDR_W-1:2],2'b00}.
  - In the redirect cycle: no push, no pop, instr_valid forced 0.
  - State is unchanged, except that redirect together with halt_req in FETCH -> HALT with the new pc.
- Halt in FETCH: fetch stops in that same cycle. Queued entries remain poppable. busy falls when count reaches 0.
- start together with halt_req in FETCH: halt wins. start in FETCH is ignored.
- start in HALT: fetching resumes from the held pc; the queue is not flushed.
- Entries hold their data while instr_valid && !instr_ready (stable head).

Test Plan:
- Reset with rst_n=0, then start with instr_ready=1: imem_addr goes 0,4,8,C on successive cycles; instr_valid rises 1 cycle after the first fetch; instr_pc/instr_out track the ROM contents at 0,4,8 with no gaps.
- Backpressure: hold instr_ready=0 for 5 cycles after start: count saturates at 2, imem_en=0 and pc frozen at 0x8. Release ready: the heads at PC 0x0 and 0x4 emerge in order and fetch resumes at 0x8.
- Redirect to 0x00000013 while 2 entries are queued: instr_valid=0 in that cycle; the next cycle has an empty queue and imem_addr=0x10; the first instruction delivered afterward has instr_pc=0x10.
- halt_req with 1 entry queued: no further imem_en; the entry pops; busy drops to 0. A start then resumes at the held pc.
- Wrap-around: redirect to 0xFFFFFFFC, start fetch: the PCs delivered are 0xFFFFFFFC then 0x00000000.
- Assert rst_n=0 asynchronously mid-stream (between clock edges): outputs clear immediately and state returns to IDLE; no fetch until start.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller: drives a combinational instruction ROM
// and feeds decode through a 2-entry queue with redirect flush and start/halt control.
module fetch_sequencer #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_en,
  input  logic [DATA_W-1:0] imem_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        count;
  logic [ADDR_W-1:0] q_pc0, q_pc1;
  logic [DATA_W-1:0] q_data0, q_data1;
  logic              push, pop;
  logic [ADDR_W-1:0] redirect_aligned;

  assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

  // A redirect cycle neither captures a fetched word nor hands one to decode.
  assign push        = (state == FETCH) && (count < 2'd2) && !redirect_valid && !halt_req;
  assign instr_valid = (count != 2'd0) && !redirect_valid;
  assign pop         = instr_valid && instr_ready;

  assign imem_addr = pc;
  assign imem_en   = push;
  assign instr_out = q_data0;
  assign instr_pc  = q_pc0;
  assign busy      = (state == FETCH) || (count != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      count   <= 2'd0;
      q_pc0   <= '0;
      q_pc1   <= '0;
      q_data0 <= '0;
      q_data1 <= '0;
    end else begin
      case (state)
        IDLE:    if (start) state <= FETCH;
        FETCH:   if (halt_req) state <= HALT;
        HALT:    if (start) state <= FETCH;
        default: state <= IDLE;
      endcase

      if (redirect_valid) begin
        count <= 2'd0;
        pc    <= redirect_aligned;
      end else begin
        // Push with pop only happens at count==1, so the new word becomes the head.
        case ({push, pop})
          2'b10: begin
            if (count == 2'd0) begin
              q_pc0   <= pc;
              q_data0 <= imem_data;
            end else begin
              q_pc1   <= pc;
              q_data1 <= imem_data;
            end
            count <= count + 2'd1;
          end
          2'b01: begin
            q_pc0   <= q_pc1;
            q_data0 <= q_data1;
            count   <= count - 2'd1;
          end
          2'b11: begin
            q_pc0   <= pc;
            q_data0 <= imem_data;
          end
          default: ;
        endcase
        if (push) pc <= pc + ADDR_W'(PC_STEP);
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based behavioural model.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start, halt_req, redirect_valid, instr_ready;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_data, instr_out, instr_pc;
  logic        imem_en, instr_valid, busy;

  int checks   = 0;
  int failures = 0;

  fetch_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_en        (imem_en),
    .imem_data      (imem_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .busy           (busy)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  assign imem_data = rom_word(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after the edge and return before the falling edge.
  task automatic applyStimulus(input logic s, input logic h, input logic rv,
                               input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    start          = s;
    halt_req       = h;
    redirect_valid = rv;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    #3;
  endtask

  // Behavioural model: a PC, a fetching flag and a FIFO of (pc, word) pairs.
  logic [31:0] m_pc;
  logic        m_fetching;
  logic [31:0] m_qpc[$];
  logic [31:0] m_qdata[$];
  logic        e_push, e_valid;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pc       = 32'h0;
      m_fetching = 1'b0;
      m_qpc.delete();
      m_qdata.delete();
      checkOutput("rst_imem_en", imem_en, 1'b0);
      checkOutput("rst_valid", instr_valid, 1'b0);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_addr", imem_addr, 32'h0);
      checkOutput("rst_instr_pc", instr_pc, 32'h0);
      checkOutput("rst_instr_out", instr_out, 32'h0);
    end else begin
      e_push  = m_fetching && (m_qpc.size() < 2) && !redirect_valid && !halt_req;
      e_valid = (m_qpc.size() != 0) && !redirect_valid;
      checkOutput("imem_addr", imem_addr, m_pc);
      checkOutput("imem_en", imem_en, e_push);
      checkOutput("instr_valid", instr_valid, e_valid);
      checkOutput("busy", busy, m_fetching || (m_qpc.size() != 0));
      if (e_valid) begin
        checkOutput("instr_pc", instr_pc, m_qpc[0]);
        checkOutput("instr_out", instr_out, m_qdata[0]);
      end
      if (redirect_valid) begin
        m_qpc.delete();
        m_qdata.delete();
        m_pc = redirect_pc & 32'hFFFFFFFC;
      end else begin
        if (e_valid && instr_ready) begin
          m_qpc.delete(0);
          m_qdata.delete(0);
        end
        if (e_push) begin
          m_qpc.push_back(m_pc);
          m_qdata.push_back(rom_word(m_pc));
          m_pc = m_pc + 32'd4;
        end
      end
      if (m_fetching && halt_req) m_fetching = 1'b0;
      else if (!m_fetching && start) m_fetching = 1'b1;
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; instr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #4;
    checkOutput("lit_rst_addr", imem_addr, 32'h0);
    checkOutput("lit_rst_valid", instr_valid, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Start with decode always ready: one instruction per cycle after one cycle.
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("lit_idle_en", imem_en, 1'b0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lit_f0_addr", imem_addr, 32'h0);
    checkOutput("lit_f0_en", imem_en, 1'b1);
    checkOutput("lit_f0_valid", instr_valid, 1'b0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lit_f1_addr", imem_addr, 32'h4);
    checkOutput("lit_f1_valid", instr_valid, 1'b1);
    checkOutput("lit_f1_pc", instr_pc, 32'h0);
    checkOutput("lit_f1_out", instr_out, 32'h5A5A0F0F);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lit_f2_addr", imem_addr, 32'h8);
    checkOutput("lit_f2_pc", instr_pc, 32'h4);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lit_f3_addr", imem_addr, 32'hC);
    checkOutput("lit_f3_pc", instr_pc, 32'h8);

    // Halt, rewind to 0 while halted, then restart under backpressure.
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("lit_h_en", imem_en, 1'b0);
    checkOutput("lit_h_pc", instr_pc, 32'hC);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("lit_rd_busy", busy, 1'b0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("lit_bp_start_addr", imem_addr, 32'h0);
    checkOutput("lit_bp_start_en", imem_en, 1'b0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 0, 0, 0);
      if (k >= 2) begin
        checkOutput("lit_bp_full_en", imem_en, 1'b0);
        checkOutput("lit_bp_full_addr", imem_addr, 32'h8);
        checkOutput("lit_bp_head", instr_pc, 32'h0);
      end
    end
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lit_rel0_pc", instr_pc, 32'h0);
    checkOutput("lit_rel0_en", imem_en, 1'b0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lit_rel1_pc", instr_pc, 32'h4);
    checkOutput("lit_rel1_en", imem_en, 1'b1);
    checkOutput("lit_rel1_addr", imem_addr, 32'h8);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lit_rel2_pc", instr_pc, 32'h8);

    // Fill the queue, then redirect to an unaligned target.
    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h13, 1);
    checkOutput("lit_redir_valid", instr_valid, 1'b0);
    checkOutput("lit_redir_en", imem_en, 1'b0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lit_redir_addr", imem_addr, 32'h10);
    checkOutput("lit_redir_empty", instr_valid, 1'b0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lit_redir_first", instr_pc, 32'h10);

    // Halt with one entry queued; it drains and busy drops, then resume.
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("lit_halt_en", imem_en, 1'b0);
    checkOutput("lit_halt_pc", instr_pc, 32'h14);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lit_drain_valid", instr_valid, 1'b1);
    checkOutput("lit_drain_busy", busy, 1'b1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lit_drained_busy", busy, 1'b0);
    checkOutput("lit_held_addr", imem_addr, 32'h18);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lit_resume_en", imem_en, 1'b1);
    checkOutput("lit_resume_addr", imem_addr, 32'h18);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lit_resume_pc", instr_pc, 32'h18);

    // Wrap-around from the top of the address space.
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 0, 1, 32'hFFFFFFFC, 1);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lit_wrap_addr", imem_addr, 32'hFFFFFFFC);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lit_wrap_pc0", instr_pc, 32'hFFFFFFFC);
    checkOutput("lit_wrap_addr0", imem_addr, 32'h0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lit_wrap_pc1", instr_pc, 32'h0);

    // Asynchronous reset between clock edges while streaming.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("lit_arst_valid", instr_valid, 1'b0);
    checkOutput("lit_arst_busy", busy, 1'b0);
    checkOutput("lit_arst_en", imem_en, 1'b0);
    checkOutput("lit_arst_addr", imem_addr, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("lit_post_rst_en", imem_en, 1'b0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        @(posedge clk);
        #3 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
      applyStimulus($urandom_range(0, 9) == 0,
                    $urandom_range(0, 19) == 0,
                    $urandom_range(0, 19) == 0,
                    ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                                : 32'($urandom),
                    $urandom_range(0, 9) < 7);
    end

    @(posedge clk);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
